// File: rtl/i2c_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_bridge
//  Description : System-clock register bank and timing-trace FIFO fed by the
//                SCL-domain bridge signals of the I2C slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_bridge #(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         TRACE_DEPTH = 64,
    parameter int         POP_FILT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  i2c_addr,
    input  logic        i2c_read,
    input  logic        i2c_write,
    input  logic [7:0]  i2c_write_data,
    output logic [7:0]  i2c_read_data,
    input  logic        i2c_rd_pop,
    input  logic        i2c_trace_rd_reset,
    input  logic        trace_valid,
    input  logic [7:0]  trace_data,
    output logic [63:0] ctrl_regs,
    input  logic [31:0] stat_in,
    output logic        wr_pulse,
    output logic [2:0]  wr_index,
    output logic        trace_overflow
);

    localparam int c_AW = $clog2(TRACE_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_PW = $clog2(POP_FILT + 1);

    // Synchronizer stages; the _prev flops provide rising-edge detection.
    logic             r_write_s1, r_write_s2, r_write_prev;
    logic             r_pop_s1, r_pop_s2;
    logic             r_trrst_s1, r_trrst_s2, r_trrst_prev;
    logic [5:0]       r_addr_s1, r_addr_s2;
    logic [7:0]       r_wdata_s1, r_wdata_s2;
    logic [c_PW-1:0]  r_pop_cnt;

    logic [63:0]      r_ctrl;
    logic             r_wr_pulse;
    logic [2:0]       r_wr_index;
    logic [7:0]       r_read_data;

    logic [7:0]       r_mem [TRACE_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;

    logic             w_write_evt, w_ctrl_hit, w_pop_evt, w_trrst_rise;
    logic             w_empty, w_full, w_push, w_pop, w_drop;
    logic [7:0]       w_head, w_count8, w_rd_mux;
    logic             w_unused_read;

    // The read-in-progress flag is informational only.
    assign w_unused_read = i2c_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_s1   <= 1'b0;
            r_write_s2   <= 1'b0;
            r_write_prev <= 1'b0;
            r_pop_s1     <= 1'b0;
            r_pop_s2     <= 1'b0;
            r_trrst_s1   <= 1'b0;
            r_trrst_s2   <= 1'b0;
            r_trrst_prev <= 1'b0;
            r_addr_s1    <= '0;
            r_addr_s2    <= '0;
            r_wdata_s1   <= '0;
            r_wdata_s2   <= '0;
        end else begin
            r_write_s1   <= i2c_write;
            r_write_s2   <= r_write_s1;
            r_write_prev <= r_write_s2;
            r_pop_s1     <= i2c_rd_pop;
            r_pop_s2     <= r_pop_s1;
            r_trrst_s1   <= i2c_trace_rd_reset;
            r_trrst_s2   <= r_trrst_s1;
            r_trrst_prev <= r_trrst_s2;
            r_addr_s1    <= i2c_addr;
            r_addr_s2    <= r_addr_s1;
            r_wdata_s1   <= i2c_write_data;
            r_wdata_s2   <= r_wdata_s1;
        end
    end

    assign w_write_evt  = r_write_s2 & ~r_write_prev;
    assign w_trrst_rise = r_trrst_s2 & ~r_trrst_prev;
    assign w_ctrl_hit   = (r_addr_s2[5:3] == 3'b001);

    // Pop fires once, on the cycle the saturating run-length count reaches POP_FILT.
    assign w_pop_evt = r_pop_s2 && (r_pop_cnt == c_PW'(POP_FILT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_cnt <= '0;
        end else if (!r_pop_s2) begin
            r_pop_cnt <= '0;
        end else if (r_pop_cnt != c_PW'(POP_FILT)) begin
            r_pop_cnt <= r_pop_cnt + c_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_index <= '0;
        end else begin
            r_wr_pulse <= w_write_evt && w_ctrl_hit;
            if (w_write_evt && w_ctrl_hit) begin
                r_ctrl[{r_addr_s2[2:0], 3'b000} +: 8] <= r_wdata_s2;
                r_wr_index                            <= r_addr_s2[2:0];
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CW'(TRACE_DEPTH));
    assign w_push  = trace_valid && (!w_full || w_pop_evt);
    assign w_pop   = w_pop_evt && !w_empty;
    assign w_drop  = trace_valid && w_full && !w_pop_evt;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= trace_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
            // A drop in the same cycle as the window opening keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_trrst_rise) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_count8             = '0;
        w_count8[c_CW-1:0]   = r_count;
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (r_addr_s2 == 6'h00) begin
            w_rd_mux = ID_VALUE;
        end else if (r_addr_s2 == 6'h01) begin
            w_rd_mux = {w_empty, w_full, r_overflow, 5'b00000};
        end else if (r_addr_s2 == 6'h02) begin
            w_rd_mux = w_count8;
        end else if (w_ctrl_hit) begin
            w_rd_mux = r_ctrl[{r_addr_s2[2:0], 3'b000} +: 8];
        end else if (r_addr_s2[5:2] == 4'b0100) begin
            w_rd_mux = stat_in[{r_addr_s2[1:0], 3'b000} +: 8];
        end else if (r_addr_s2[5:4] == 2'b11) begin
            w_rd_mux = w_empty ? 8'h00 : w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else begin
            r_read_data <= w_rd_mux;
        end
    end

    assign i2c_read_data  = r_read_data;
    assign ctrl_regs      = r_ctrl;
    assign wr_pulse       = r_wr_pulse;
    assign wr_index       = r_wr_index;
    assign trace_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg_bridge
//  Description : Scoreboard bench for i2c_reg_bridge with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_reg_bridge;

    localparam int c_K_RDATA = 0;
    localparam int c_K_CTRL  = 1;
    localparam int c_K_OVF   = 2;
    localparam int c_K_PULSE = 3;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  idx;
        logic [63:0] regs;
    } wexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  i2c_addr = '0;
    logic        i2c_read = 1'b0;
    logic        i2c_write = 1'b0;
    logic [7:0]  i2c_write_data = '0;
    logic [7:0]  i2c_read_data;
    logic        i2c_rd_pop = 1'b0;
    logic        i2c_trace_rd_reset = 1'b0;
    logic        trace_valid = 1'b0;
    logic [7:0]  trace_data = '0;
    logic [63:0] ctrl_regs;
    logic [31:0] stat_in = 32'h44332211;
    logic        wr_pulse;
    logic [2:0]  wr_index;
    logic        trace_overflow;

    int          checks = 0;
    int          failures = 0;
    logic        smp_req = 1'b0;
    exp_t        smp_q[$];
    wexp_t       wq[$];
    logic [63:0] m_ctrl = '0;

    always #5 clk = ~clk;

    i2c_reg_bridge #(
        .ID_VALUE    (8'hA5),
        .TRACE_DEPTH (64),
        .POP_FILT    (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i2c_addr           (i2c_addr),
        .i2c_read           (i2c_read),
        .i2c_write          (i2c_write),
        .i2c_write_data     (i2c_write_data),
        .i2c_read_data      (i2c_read_data),
        .i2c_rd_pop         (i2c_rd_pop),
        .i2c_trace_rd_reset (i2c_trace_rd_reset),
        .trace_valid        (trace_valid),
        .trace_data         (trace_data),
        .ctrl_regs          (ctrl_regs),
        .stat_in            (stat_in),
        .wr_pulse           (wr_pulse),
        .wr_index           (wr_index),
        .trace_overflow     (trace_overflow)
    );

    // Monitor: write expectations are consumed by wr_pulse, sample expectations by smp_req.
    always @(negedge clk) begin
        exp_t        e;
        wexp_t       w;
        logic [63:0] act;
        if (wr_pulse) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL wr_pulse_unexpected: got pulse idx=%0d ctrl=%h, none expected", wr_index, ctrl_regs);
            end else begin
                w = wq.pop_front();
                if (wr_index !== w.idx || ctrl_regs !== w.regs) begin
                    failures++;
                    $display("FAIL wr_commit: got idx=%0d ctrl=%h, expected idx=%0d ctrl=%h",
                             wr_index, ctrl_regs, w.idx, w.regs);
                end
            end
        end
        if (smp_req) begin
            while (smp_q.size() > 0) begin
                e = smp_q.pop_front();
                case (e.kind)
                    c_K_RDATA: act = {56'd0, i2c_read_data};
                    c_K_CTRL:  act = ctrl_regs;
                    c_K_OVF:   act = {63'd0, trace_overflow};
                    default:   act = {63'd0, wr_pulse};
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input int kind, input logic [63:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        smp_q.push_back(e);
        smp_req = 1'b1;
        @(negedge clk);
        #1;
        smp_req = 1'b0;
    endtask

    task automatic set_addr(input logic [5:0] a);
        i2c_addr = a;
        tick(3);
    endtask

    task automatic write_i2c(input logic [5:0] a, input logic [7:0] d, input int hold);
        wexp_t w;
        i2c_addr       = a;
        i2c_write_data = d;
        tick(4);
        if (a >= 6'h08 && a <= 6'h0F) begin
            m_ctrl[a[2:0]*8 +: 8] = d;
            w.idx  = a[2:0];
            w.regs = m_ctrl;
            wq.push_back(w);
        end
        i2c_write = 1'b1;
        tick(hold);
        i2c_write = 1'b0;
        tick(4);
    endtask

    task automatic pop_req(input int n);
        i2c_rd_pop = 1'b1;
        tick(n);
        i2c_rd_pop = 1'b0;
        tick(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_ctrl = '0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wexp_t w;
        tick(3);
        expect_now(c_K_RDATA, 64'h0, "reset_read_data");
        expect_now(c_K_CTRL,  64'h0, "reset_ctrl");
        expect_now(c_K_PULSE, 64'h0, "reset_wr_pulse");
        expect_now(c_K_OVF,   64'h0, "reset_overflow");
        reset = 1'b0;
        tick(2);

        // Test 1: write 0x5C to 0x0A with latency checks
        i2c_addr       = 6'h0A;
        i2c_write_data = 8'h5C;
        tick(4);
        m_ctrl[23:16] = 8'h5C;
        w.idx  = 3'd2;
        w.regs = m_ctrl;
        wq.push_back(w);
        i2c_write = 1'b1;
        tick(2);
        expect_now(c_K_CTRL, 64'h0, "t1_ctrl_before_3clk");
        tick(1);
        expect_now(c_K_CTRL, 64'h0000_0000_005C_0000, "t1_ctrl_at_3clk");
        tick(12);
        i2c_write = 1'b0;
        tick(4);
        expect_now(c_K_PULSE, 64'h0, "t1_pulse_low_after");

        // Test 2: held write gives one event; write outside ctrl window ignored
        write_i2c(6'h09, 8'h11, 40);
        expect_now(c_K_CTRL, 64'h0000_0000_005C_1100, "t2_ctrl_held_write");
        write_i2c(6'h05, 8'hFF, 16);
        expect_now(c_K_CTRL, 64'h0000_0000_005C_1100, "t2_ctrl_ignored_write");

        // Test 3: read mux
        set_addr(6'h00);
        expect_now(c_K_RDATA, 64'hA5, "t3_id");
        set_addr(6'h12);
        expect_now(c_K_RDATA, 64'h33, "t3_stat_byte2");
        set_addr(6'h0A);
        expect_now(c_K_RDATA, 64'h5C, "t3_ctrl_readback");
        set_addr(6'h3F);
        expect_now(c_K_RDATA, 64'h00, "t3_trace_empty");

        // Test 4: fill to 64, one extra is dropped
        for (int i = 1; i <= 65; i++) begin
            trace_valid = 1'b1;
            trace_data  = 8'(i);
            tick(1);
        end
        trace_valid = 1'b0;
        set_addr(6'h02);
        expect_now(c_K_RDATA, 64'h40, "t4_count_full");
        set_addr(6'h01);
        expect_now(c_K_RDATA, 64'h60, "t4_status_full_ovf");
        expect_now(c_K_OVF, 64'h1, "t4_overflow_set");
        i2c_trace_rd_reset = 1'b1;
        tick(5);
        expect_now(c_K_OVF, 64'h0, "t4_overflow_cleared");
        i2c_trace_rd_reset = 1'b0;
        tick(2);

        // Test 6a: full FIFO, push coincides with pop event (commits 5 clk after rd_pop rise)
        i2c_rd_pop = 1'b1;
        tick(4);
        trace_valid = 1'b1;
        trace_data  = 8'h99;
        tick(1);
        trace_valid = 1'b0;
        tick(5);
        i2c_rd_pop = 1'b0;
        tick(4);
        set_addr(6'h02);
        expect_now(c_K_RDATA, 64'h40, "t6_count_unchanged");
        expect_now(c_K_OVF, 64'h0, "t6_no_overflow");
        set_addr(6'h30);
        expect_now(c_K_RDATA, 64'h02, "t6_head_advanced");

        // Test 5: glitch filter and draining
        do_reset();
        expect_now(c_K_CTRL, 64'h0, "t5_ctrl_after_reset");
        trace_valid = 1'b1;
        trace_data  = 8'h07;
        tick(1);
        trace_data  = 8'h08;
        tick(1);
        trace_valid = 1'b0;
        set_addr(6'h30);
        expect_now(c_K_RDATA, 64'h07, "t5_head_first");
        pop_req(1);
        tick(4);
        expect_now(c_K_RDATA, 64'h07, "t5_glitch_ignored");
        pop_req(10);
        expect_now(c_K_RDATA, 64'h08, "t5_head_after_pop");
        set_addr(6'h02);
        expect_now(c_K_RDATA, 64'h01, "t5_count_one");
        set_addr(6'h30);
        pop_req(10);
        expect_now(c_K_RDATA, 64'h00, "t5_empty_reads_zero");
        pop_req(10);
        set_addr(6'h01);
        expect_now(c_K_RDATA, 64'h80, "t5_status_empty_no_flag");
        set_addr(6'h02);
        expect_now(c_K_RDATA, 64'h00, "t5_count_zero");

        // Test 6b: reset during a write commits nothing
        i2c_addr       = 6'h0B;
        i2c_write_data = 8'h77;
        tick(4);
        i2c_write = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(2);
        i2c_write = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(8);
        expect_now(c_K_CTRL, 64'h0, "t6_ctrl_after_reset_mid_write");
        expect_now(c_K_PULSE, 64'h0, "t6_no_pulse");

        tick(4);
        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL missing_wr_pulse: got %0d unconsumed, expected 0", wq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
- System-clock register bank and trace FIFO downstream of the I2C slave.
- Consumes the slave's SCL-domain bridge signals: addr, write, write_data, rd_pop, trace_rd_reset.
- Returns read_data to the slave.
- Synchronizes all strobes into clk, owns 8 control registers and 4 status bytes, and buffers 8-bit timing-trace bytes that the host drains at logical addresses 0x30-0x3F.

Parameters:
- ID_VALUE, 8'hA5, constant returned at address 0x00.
- TRACE_DEPTH, 64, trace FIFO entries; power of 2, range 4..128.
- POP_FILT, 3, consecutive synchronized-high clk cycles required to accept rd_pop.

Ports:
- clk  in  1  system clock; must be ≥16x SCL frequency.
- reset  in  1  synchronous, active-high reset.
- i2c_addr  in  6  logical register address (SCL domain).
- i2c_read  in  1  read in progress (SCL domain); status only, does not gate read data.
- i2c_write  in  1  write strobe, high for one SCL period (SCL domain).
- i2c_write_data  in  8  write byte; stable while i2c_write is high.
- i2c_read_data  out  8  read byte returned to the slave.
- i2c_rd_pop  in  1  trace pop request (SCL domain, may glitch).
- i2c_trace_rd_reset  in  1  trace window selected (SCL domain).
- trace_valid  in  1  trace byte push request.
- trace_data  in  8  trace byte.
- ctrl_regs  out  64  control registers 0x08-0x0F; byte n = address 0x08+n.
- stat_in  in  32  status bytes at 0x10-0x13; byte n = address 0x10+n.
- wr_pulse  out  1  one-clk pulse on each accepted write to 0x08-0x0F.
- wr_index  out  3  index of the last written control register.
- trace_overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset: ctrl_regs=0, i2c_read_data=0, wr_pulse=0, wr_index=0, trace_overflow=0, FIFO emptied, all synchronizer and filter flops cleared.
- Synchronizers:
  - i2c_write, i2c_rd_pop and i2c_trace_rd_reset each pass through 2 flops.
  - i2c_addr[5:0] passes through 2 flops as a bus; it is treated as quasi-static.
- Write path:
  - The rising edge of synced write (prev=0, now=1) forms a 1-clk write event.
  - i2c_addr and i2c_write_data are sampled from their synced copies in that cycle.
  - Total latency from the i2c_write rise to the ctrl_regs update is 3 clk; wr_pulse goes high in that same cycle.
  - A held-high write produces exactly one event.
- Address map:
  - 0x00 reads ID_VALUE.
  - 0x01 reads {empty, full, trace_overflow, 5'b0}.
  - 0x02 reads FIFO count, zero-extended to 8 bits.
  - 0x08-0x0F are RW control registers.
  - 0x10-0x13 read stat_in.
  - 0x30-0x3F read the FIFO head, or 0x00 when empty.
  - All other addresses read 0x00.
  - Writes to any address outside 0x08-0x0F are ignored.
- Read path:
  - i2c_read_data is registered every clk from a mux on the synced addr.
  - Latency is 3 clk from an i2c_addr change, and 1 clk from a FIFO head change.
- Pop filter:
  - A shift counter counts consecutive synced-high cycles of rd_pop, saturating at POP_FILT.
  - A pop event fires once, on the cycle the count reaches POP_FILT.
  - The counter clears when synced rd_pop is low.
  - Glitches shorter than POP_FILT clk never pop.
- FIFO (read/write pointers plus a count register of width log2(TRACE_DEPTH)+1):
  - Push when trace_valid && (!full || pop_event).
  - trace_valid && full && !pop_event drops the byte and sets trace_overflow.
  - Pop when pop_event && !empty; a pop on empty is ignored with no flag.
  - Simultaneous push and pop: both occur, count unchanged.
  - Both pointers wrap modulo TRACE_DEPTH.
- Trace window: the rising edge of synced trace_rd_reset clears trace_overflow. If this coincides with a drop in the same cycle, the set wins.
- Reset mid-transfer discards any pending synchronized events; no partial write is committed.

Test Plan:
1. Reset, then I2C-model write of 0x5C to addr 0x0A → ctrl_regs[23:16]=0x5C 3 clk after i2c_write rises; wr_pulse exactly 1 clk; wr_index=2; all other bytes 0.
2. Hold i2c_write high for 40 clk with addr 0x09, data 0x11 → exactly one wr_pulse; write to 0x05 → no register change, no wr_pulse.
3. Set addr 0x00 → i2c_read_data=0xA5 within 3 clk; addr 0x12 with stat_in=0x44332211 → 0x33.
4. Push 0x01..0x40 (64 bytes), then one more → count reads 0x40, full=1, trace_overflow=1, byte 0x41 lost; trace_rd_reset rise → overflow cleared.
5. addr 0x30 with FIFO holding 0x07,0x08 → read_data=0x07; rd_pop high 1 clk (glitch) → still 0x07; rd_pop high 10 clk → 0x08, count=1; second long pop → empty, read_data=0x00; third pop → no change.
6. FIFO full plus simultaneous push and pop_event → both occur, count stays 64, no overflow; assert reset mid-write → ctrl_regs stay 0.
